// File: rtl/irq_ack_sequencer_pkg.sv
// Shared definitions for the IRQ acknowledge sequencer.
//   state_t      : sequencer states (IDLE, ACK, SAVE, VECTOR, HANDLER, RETURN)
//   PC_SEQ/RET/VEC: encodings of the PC source select
//   IRQ_VECTOR   : handler entry address
//   MODE_IRQ     : CPSR mode field value for IRQ mode
//   irq_mode_psr : CPSR value used on handler entry (I mask set, IRQ mode)
package irq_ack_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACK     = 3'd1,
    SAVE    = 3'd2,
    VECTOR  = 3'd3,
    HANDLER = 3'd4,
    RETURN  = 3'd5
  } state_t;

  localparam logic [1:0]  PC_SEQ     = 2'b00;
  localparam logic [1:0]  PC_RET     = 2'b10;
  localparam logic [1:0]  PC_VEC     = 2'b11;
  localparam logic [31:0] IRQ_VECTOR = 32'h0000_0018;
  localparam logic [4:0]  MODE_IRQ   = 5'b10010;

  // Handler-entry PSR: keep condition flags and other bits, mask IRQs and
  // switch the mode field to IRQ.
  function automatic logic [31:0] irq_mode_psr(input logic [31:0] psr);
    return {psr[31:8], 1'b1, psr[6:5], MODE_IRQ};
  endfunction

endpackage

// File: rtl/irq_ack_sequencer.sv
// IRQ acknowledge sequencer.
// Takes an unmasked IRQ at an instruction boundary, acknowledges it, saves
// the return context into banked registers, switches CPSR to IRQ mode,
// vectors the PC to the handler and, on eret, restores PC and CPSR.
// Outputs are decoded from the registered state only (Moore).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   INT_irq    in   pending IRQ
//   instr_done in   instruction boundary
//   eret       in   retiring instruction is an IRQ return (with instr_done)
//   pc_next    in   [31:0] next sequential PC
//   cpsr_in    in   [31:0] current CPSR (bit 7 = I mask, 4:0 = mode)
//   INTA_irq   out  acknowledge pulse
//   PC_s       out  [1:0] PC source select
//   Write_PC   out  PC write strobe
//   pc_target  out  [31:0] PC value when Write_PC=1
//   cpsr_wr    out  CPSR write strobe
//   cpsr_out   out  [31:0] CPSR value when cpsr_wr=1
//   lr_irq     out  [31:0] banked IRQ link register
//   spsr_irq   out  [31:0] banked IRQ saved PSR
//   stall      out  freezes fetch/issue
//   in_irq     out  handler executing
//   irq_count  out  [15:0] ACK entries, wrapping (only with IRQ_ACK_STATS_EN)
//
// Build option: define IRQ_ACK_STATS_EN to add the irq_count statistic.
module irq_ack_sequencer
  import irq_ack_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        INT_irq,
  input  logic        instr_done,
  input  logic        eret,
  input  logic [31:0] pc_next,
  input  logic [31:0] cpsr_in,
  output logic        INTA_irq,
  output logic [1:0]  PC_s,
  output logic        Write_PC,
  output logic [31:0] pc_target,
  output logic        cpsr_wr,
  output logic [31:0] cpsr_out,
  output logic [31:0] lr_irq,
  output logic [31:0] spsr_irq,
  output logic        stall,
`ifdef IRQ_ACK_STATS_EN
  output logic [15:0] irq_count,
`endif
  output logic        in_irq
);

  state_t state;
  state_t state_next;
  logic   take_irq;

  // Accept only at an instruction boundary with IRQs unmasked.
  assign take_irq = (state == IDLE) && INT_irq && instr_done && !cpsr_in[7];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation ordering cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lr_irq   <= '0;
      spsr_irq <= '0;
    end else begin
      state <= state_next;
      // The context is captured on the edge that enters ACK, so the values
      // belong to the boundary that was interrupted and are already valid
      // while ACK is displayed.
      if (take_irq) begin
        lr_irq   <= pc_next + 32'd4;
        spsr_irq <= cpsr_in;
      end
    end
  end

`ifdef IRQ_ACK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_count <= '0;
    end else if (take_irq) begin
      irq_count <= irq_count + 16'd1;
    end
  end
`endif

  // NOTE: every signal driven here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    INTA_irq   = 1'b0;
    PC_s       = PC_SEQ;
    Write_PC   = 1'b0;
    pc_target  = '0;
    cpsr_wr    = 1'b0;
    cpsr_out   = '0;
    stall      = 1'b0;
    in_irq     = 1'b0;

    unique case (state)
      IDLE: begin
        // eret is deliberately ignored here.
        if (take_irq) state_next = ACK;
      end
      ACK: begin
        INTA_irq   = 1'b1;
        stall      = 1'b1;
        state_next = SAVE;
      end
      SAVE: begin
        cpsr_wr    = 1'b1;
        cpsr_out   = irq_mode_psr(spsr_irq);
        stall      = 1'b1;
        state_next = VECTOR;
      end
      VECTOR: begin
        PC_s       = PC_VEC;
        Write_PC   = 1'b1;
        pc_target  = IRQ_VECTOR;
        stall      = 1'b1;
        state_next = HANDLER;
      end
      HANDLER: begin
        // INT_irq is not looked at: a request arriving together with eret
        // is picked up from IDLE at the following boundary.
        in_irq = 1'b1;
        if (eret && instr_done) state_next = RETURN;
      end
      RETURN: begin
        PC_s       = PC_RET;
        Write_PC   = 1'b1;
        pc_target  = lr_irq - 32'd4;
        cpsr_wr    = 1'b1;
        cpsr_out   = spsr_irq;
        stall      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_irq_ack_sequencer.sv
// Self-checking bench for irq_ack_sequencer.
// A queue-based reference model predicts the outputs of every cycle; a
// compare process checks them on the falling edge, and directed scenarios
// add hand-computed literal checks. Define IRQ_ACK_STATS_EN to also check
// irq_count.
module tb_irq_ack_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        INT_irq;
  logic        instr_done;
  logic        eret;
  logic [31:0] pc_next;
  logic [31:0] cpsr_in;
  logic        INTA_irq;
  logic [1:0]  PC_s;
  logic        Write_PC;
  logic [31:0] pc_target;
  logic        cpsr_wr;
  logic [31:0] cpsr_out;
  logic [31:0] lr_irq;
  logic [31:0] spsr_irq;
  logic        stall;
  logic        in_irq;
`ifdef IRQ_ACK_STATS_EN
  logic [15:0] irq_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  irq_ack_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .INT_irq    (INT_irq),
    .instr_done (instr_done),
    .eret       (eret),
    .pc_next    (pc_next),
    .cpsr_in    (cpsr_in),
    .INTA_irq   (INTA_irq),
    .PC_s       (PC_s),
    .Write_PC   (Write_PC),
    .pc_target  (pc_target),
    .cpsr_wr    (cpsr_wr),
    .cpsr_out   (cpsr_out),
    .lr_irq     (lr_irq),
    .spsr_irq   (spsr_irq),
    .stall      (stall),
`ifdef IRQ_ACK_STATS_EN
    .irq_count  (irq_count),
`endif
    .in_irq     (in_irq)
  );

  // ---------------- reference model ----------------
  // Expected strobes of one cycle; to_handler marks the last step of the
  // entry sequence, after which the handler runs.
  typedef struct packed {
    logic        inta;
    logic [1:0]  pc_s;
    logic        write_pc;
    logic [31:0] pc_target;
    logic        cpsr_wr;
    logic [31:0] cpsr_out;
    logic        stall;
    logic        in_irq;
    logic        to_handler;
  } step_t;

  typedef struct packed {
    logic        inta;
    logic [1:0]  pc_s;
    logic        write_pc;
    logic [31:0] pc_target;
    logic        cpsr_wr;
    logic [31:0] cpsr_out;
    logic [31:0] lr;
    logic [31:0] spsr;
    logic        stall;
    logic        in_irq;
  } obs_t;

  step_t       m_q[$];
  logic        m_handler = 1'b0;
  logic        m_valid   = 1'b0;
  logic [31:0] m_lr      = '0;
  logic [31:0] m_spsr    = '0;
  logic [15:0] m_count   = '0;

  function automatic step_t mk(input logic inta, input logic [1:0] pcs,
                               input logic wpc, input logic [31:0] tgt,
                               input logic cwr, input logic [31:0] cout,
                               input logic stl, input logic inirq,
                               input logic toh);
    step_t s;
    s.inta = inta; s.pc_s = pcs; s.write_pc = wpc; s.pc_target = tgt;
    s.cpsr_wr = cwr; s.cpsr_out = cout; s.stall = stl; s.in_irq = inirq;
    s.to_handler = toh;
    return s;
  endfunction

  always @(posedge clk) begin
    step_t s;
    logic [31:0] psr;
    if (rst) begin
      m_q.delete();
      m_handler = 1'b0;
      m_lr      = '0;
      m_spsr    = '0;
      m_count   = '0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      if (m_q.size() != 0) begin
        s = m_q.pop_front();
        if (m_q.size() == 0) m_handler = s.to_handler;
      end else if (m_handler) begin
        if (eret && instr_done) begin
          m_handler = 1'b0;
          m_q.push_back(mk(0, 2'b10, 1, m_lr - 32'd4, 1, m_spsr, 1, 0, 0));
        end
      end else if (INT_irq && instr_done && !cpsr_in[7]) begin
        m_lr   = pc_next + 32'd4;
        m_spsr = cpsr_in;
        m_count = m_count + 16'd1;
        psr = m_spsr;
        psr[7] = 1'b1;
        psr[4:0] = 5'b10010;
        m_q.push_back(mk(1, 2'b00, 0, 32'h0, 0, 32'h0, 1, 0, 0));
        m_q.push_back(mk(0, 2'b00, 0, 32'h0, 1, psr,   1, 0, 0));
        m_q.push_back(mk(0, 2'b11, 1, 32'h18, 0, 32'h0, 1, 0, 1));
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    step_t s;
    obs_t  exp_o;
    obs_t  got_o;
    if (m_valid) begin
      if (m_q.size() != 0)  s = m_q[0];
      else if (m_handler)   s = mk(0, 2'b00, 0, 32'h0, 0, 32'h0, 0, 1, 0);
      else                  s = mk(0, 2'b00, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      exp_o = '{s.inta, s.pc_s, s.write_pc, s.pc_target, s.cpsr_wr,
                s.cpsr_out, m_lr, m_spsr, s.stall, s.in_irq};
      got_o = '{INTA_irq, PC_s, Write_PC, pc_target, cpsr_wr, cpsr_out,
                lr_irq, spsr_irq, stall, in_irq};
      vectors++;
      if (got_o !== exp_o) begin
        miscompares++;
        $display("FAIL cycle_outputs @%0t got=%h exp=%h", $time, got_o, exp_o);
      end
`ifdef IRQ_ACK_STATS_EN
      vectors++;
      if (irq_count !== m_count) begin
        miscompares++;
        $display("FAIL irq_count @%0t got=%h exp=%h", $time, irq_count, m_count);
      end
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp_v);
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL %s @%0t got=%h exp=%h", name, $time, got, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; INT_irq = 1'b0; instr_done = 1'b0; eret = 1'b0;
    pc_next = '0; cpsr_in = '0;
    tick(); tick();
    check("rst_inta",   INTA_irq, 0);
    check("rst_wpc",    Write_PC, 0);
    check("rst_cpsrwr", cpsr_wr,  0);
    check("rst_stall",  stall,    0);
    check("rst_lr",     lr_irq,   0);
    check("rst_spsr",   spsr_irq, 0);
`ifdef IRQ_ACK_STATS_EN
    check("rst_count",  irq_count, 0);
`endif
    rst = 1'b0;
    tick();

    // Basic IRQ entry
    cpsr_in = 32'h13; pc_next = 32'h100; INT_irq = 1; instr_done = 1;
    tick();                                           // N+1
    check("basic_inta",  INTA_irq, 1);
    check("basic_stall", stall, 1);
    INT_irq = 0; instr_done = 0;
    tick();                                           // N+2
    check("basic_cpsrwr", cpsr_wr, 1);
    check("basic_cpsr",   cpsr_out, 32'h92);
    check("basic_lr",     lr_irq, 32'h104);
    check("basic_spsr",   spsr_irq, 32'h13);
    tick();                                           // N+3
    check("basic_wpc",  Write_PC, 1);
    check("basic_pcs",  PC_s, 2'b11);
    check("basic_tgt",  pc_target, 32'h18);
    tick();                                           // N+4
    check("basic_inirq", in_irq, 1);
    check("basic_run",   stall, 0);

    // INT_irq ignored inside the handler
    INT_irq = 1; instr_done = 1;
    tick(); tick();
    check("hdl_ignore_inta", INTA_irq, 0);
    check("hdl_inirq",       in_irq, 1);

    // Return
    INT_irq = 0; eret = 1; instr_done = 1;
    tick();
    check("ret_pcs",    PC_s, 2'b10);
    check("ret_tgt",    pc_target, 32'h100);
    check("ret_cpsr",   cpsr_out, 32'h13);
    check("ret_cpsrwr", cpsr_wr, 1);
    eret = 0; instr_done = 0;
    tick();
    check("ret_idle_inirq", in_irq, 0);
    check("ret_idle_wpc",   Write_PC, 0);

    // eret in IDLE does nothing
    eret = 1; instr_done = 1;
    tick();
    check("idle_eret_wpc",  Write_PC, 0);
    tick();
    check("idle_eret_cwr",  cpsr_wr, 0);
    eret = 0; instr_done = 0;

    // Masked requests
    cpsr_in = 32'h93; INT_irq = 1; instr_done = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("masked_inta", INTA_irq, 0);
    end
    check("masked_stall", stall, 0);

    // No boundary, no entry
    cpsr_in = 32'h13; instr_done = 0;
    tick(); tick();
    check("noboundary_inta", INTA_irq, 0);
    INT_irq = 0;

    // Reset in SAVE
    pc_next = 32'h200; INT_irq = 1; instr_done = 1;
    tick();
    INT_irq = 0; instr_done = 0;
    tick();
    check("midrst_save", cpsr_wr, 1);
    rst = 1;
    tick();
    rst = 0;
    check("midrst_cwr",   cpsr_wr, 0);
    check("midrst_stall", stall, 0);
    check("midrst_lr",    lr_irq, 0);
    tick();
    check("midrst_wpc",   Write_PC, 0);

    // Priority: INT_irq held across eret
    pc_next = 32'h300; INT_irq = 1; instr_done = 1;
    tick();
    instr_done = 0;
    tick(); tick(); tick();
    check("prio_hdl", in_irq, 1);
    eret = 1; instr_done = 1;
    tick();
    check("prio_ret_pcs", PC_s, 2'b10);
    check("prio_ret_tgt", pc_target, 32'h300);
    eret = 0; instr_done = 0;
    tick();
    check("prio_idle_inta", INTA_irq, 0);
    instr_done = 1;
    tick();
    check("prio_reack", INTA_irq, 1);
`ifdef IRQ_ACK_STATS_EN
    check("prio_count", irq_count, 2);
`endif
    INT_irq = 0; instr_done = 0;
    tick(); tick(); tick();
    eret = 1; instr_done = 1;
    tick();
    eret = 0; instr_done = 0;
    tick();

    // Address wrap
    pc_next = 32'hFFFF_FFFC; INT_irq = 1; instr_done = 1;
    tick();
    INT_irq = 0; instr_done = 0;
    tick();
    check("wrap_lr", lr_irq, 32'h0);
    tick(); tick();
    eret = 1; instr_done = 1;
    tick();
    check("wrap_ret_tgt", pc_target, 32'hFFFF_FFFC);
    eret = 0; instr_done = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
